// File: rtl/axis_crc_arbiter.sv
// axis_crc_arbiter
//   Shares one byte-serial CRC-24 engine between two AXI-Stream requesters.
//   Whole frames are granted round-robin. The granted frame's payload is
//   forwarded to m_*, followed by the three CRC bytes, most significant first.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   s0_t* / s1_t*               requester byte streams (tdata, tvalid, tlast, tready)
//   m_tdata, m_tvalid, m_tlast  registered output stream; tlast marks the final CRC byte
//   m_tready                    downstream ready
//   m_tid                       granted port of the current byte (CRC_ARB_SRCID_EN only)
//
// Build option
//   CRC_ARB_SRCID_EN  adds the m_tid output
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no frame in progress; pick the next requester
// PASS  | forward granted payload bytes and fold them into the CRC
// CRC2  | emit crc[23:16]
// CRC1  | emit crc[15:8]
// CRC0  | emit crc[7:0] with m_tlast, then return to IDLE

module axis_crc_arbiter #(
  parameter logic [23:0] CRC_POLY = 24'h864CFB,
  parameter logic [23:0] CRC_INIT = 24'hB704CE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  output logic       s1_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
`ifdef CRC_ARB_SRCID_EN
  output logic       m_tid,
`endif
  input  logic       m_tready
);

  typedef enum logic [2:0] {IDLE, PASS, CRC2, CRC1, CRC0} state_t;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic [23:0] crc, crc_nxt;
  logic        slot_free;
  logic        sel_tvalid, sel_tlast;
  logic [7:0]  sel_tdata;
  logic        accept;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;

  // One byte through the serial CRC, MSB of the byte first.
  function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [7:0] d);
    logic [23:0] r;
    logic [7:0]  b;
    logic        fb;
    r = c;
    b = d;
    for (int k = 0; k < 8; k++) begin
      fb = r[23] ^ b[7];
      r  = {r[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
      b  = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    slot_free  = !m_tvalid || m_tready;
    sel_tvalid = grant ? s1_tvalid : s0_tvalid;
    sel_tlast  = grant ? s1_tlast  : s0_tlast;
    sel_tdata  = grant ? s1_tdata  : s0_tdata;
    accept     = (state == PASS) && sel_tvalid && slot_free;
    s0_tready  = (state == PASS) && !grant && slot_free;
    s1_tready  = (state == PASS) &&  grant && slot_free;

    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    crc_nxt        = crc;
    load           = 1'b0;
    load_data      = 8'h00;
    load_last      = 1'b0;

    case (state)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          // Contention goes to the port that did not win last time.
          grant_nxt      = (s0_tvalid && s1_tvalid) ? !last_grant : s1_tvalid;
          last_grant_nxt = grant_nxt;
          crc_nxt        = CRC_INIT;
          state_nxt      = PASS;
        end
      end
      PASS: begin
        if (accept) begin
          load      = 1'b1;
          load_data = sel_tdata;
          crc_nxt   = crc_byte(crc, sel_tdata);
          if (sel_tlast) state_nxt = CRC2;
        end
      end
      CRC2: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = crc[23:16];
          state_nxt = CRC1;
        end
      end
      CRC1: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = crc[15:8];
          state_nxt = CRC0;
        end
      end
      CRC0: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = crc[7:0];
          load_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      crc        <= CRC_INIT;
      m_tdata    <= 8'h00;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      crc        <= crc_nxt;
      // A load may replace a byte being taken on the same edge.
      if (load) begin
        m_tdata  <= load_data;
        m_tvalid <= 1'b1;
        m_tlast  <= load_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

`ifdef CRC_ARB_SRCID_EN
  always_ff @(posedge clk) begin
    if (reset)     m_tid <= 1'b0;
    else if (load) m_tid <= grant;
  end
`endif

endmodule
